// File: rtl/cpu_control_unit.sv
// cpu_control_unit: multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
// Each instruction is an opcode byte (high nibble = opcode) and, for opcodes
// 1-A, an operand byte. This block owns the instruction register, the operand
// latch and the saved zero flag. It drives every datapath strobe.
//
// Ports:
//   clk              system clock, rising edge
//   reset            asynchronous reset, active low
//   run              advance from FETCH_OP when high; ignored in every other state
//   mem_data         memory read data for the selected address (combinational)
//   zero_flag        ALU zero output for the current alu_op
//   pc_load          load PC from operand
//   pc_increment     PC += 1
//   addr_sel         memory address source: 0 = PC, 1 = operand
//   operand          latched operand byte
//   mem_write_enable write accumulator to mem[operand]
//   acc_load         load accumulator from the ALU result
//   alu_op           ALU operation, 0 outside EXECUTE
//   halted           high while in HALT
//   illegal          one-cycle pulse in DECODE for opcodes B-E
//   state            FSM state, for debug
module cpu_control_unit #(
  parameter bit         HALT_ON_ILLEGAL = 1'b0,
  parameter logic [3:0] ALU_PASS_B      = 4'h5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic [7:0] mem_data,
  input  logic       zero_flag,
  output logic       pc_load,
  output logic       pc_increment,
  output logic       addr_sel,
  output logic [7:0] operand,
  output logic       mem_write_enable,
  output logic       acc_load,
  output logic [3:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH_OP  = 3'd0,
    DECODE    = 3'd1,
    FETCH_ARG = 3'd2,
    EXECUTE   = 3'd3,
    HALT      = 3'd4
  } state_t;

  state_t     st;
  logic [3:0] ir;     // only the opcode nibble of the first byte is needed
  logic       z_reg;
  logic       ir_illegal;

  assign ir_illegal = (ir >= 4'hB) && (ir <= 4'hE);
  assign state      = st;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st      <= FETCH_OP;
      ir      <= 4'h0;
      operand <= 8'h00;
      z_reg   <= 1'b0;
    end else begin
      if (acc_load) z_reg <= zero_flag;
      case (st)
        FETCH_OP: if (run) begin
          ir <= mem_data[7:4];
          st <= DECODE;
        end
        DECODE: begin
          if (ir == 4'h0)      st <= FETCH_OP;
          else if (ir == 4'hF) st <= HALT;
          else if (ir_illegal) st <= HALT_ON_ILLEGAL ? HALT : FETCH_OP;
          else                 st <= FETCH_ARG;
        end
        FETCH_ARG: begin
          operand <= mem_data;
          st      <= EXECUTE;
        end
        EXECUTE: st <= FETCH_OP;
        HALT:    st <= HALT;
        default: st <= FETCH_OP;
      endcase
    end
  end

  // Strobes are decoded from state + ir. The FETCH_OP increment also follows
  // run. Everything is qualified by reset so that the outputs drop the moment
  // reset asserts. This matters because FETCH_OP would otherwise still show
  // pc_increment while run is high.
  always_comb begin
    pc_load          = 1'b0;
    pc_increment     = 1'b0;
    addr_sel         = 1'b0;
    mem_write_enable = 1'b0;
    acc_load         = 1'b0;
    alu_op           = 4'h0;
    illegal          = 1'b0;
    halted           = 1'b0;
    if (reset) begin
      case (st)
        FETCH_OP:  pc_increment = run;
        DECODE:    illegal      = ir_illegal;
        FETCH_ARG: pc_increment = 1'b1;
        EXECUTE: begin
          addr_sel = 1'b1;
          case (ir)
            4'h1: begin alu_op = ALU_PASS_B; acc_load = 1'b1; end
            4'h2: mem_write_enable = 1'b1;
            4'h3: begin alu_op = 4'h0; acc_load = 1'b1; end
            4'h4: begin alu_op = 4'h1; acc_load = 1'b1; end
            4'h5: begin alu_op = 4'h2; acc_load = 1'b1; end
            4'h6: begin alu_op = 4'h3; acc_load = 1'b1; end
            4'h7: begin alu_op = 4'h4; acc_load = 1'b1; end
            4'h8: pc_load = 1'b1;
            4'h9: pc_load = z_reg;
            4'hA: pc_load = !z_reg;
            default: ;
          endcase
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
module tb_cpu_control_unit;

  typedef struct packed {
    logic [2:0] st;
    logic       hlt, ill, pcl, pci, asel, we, accl;
    logic [3:0] op;
    logic [7:0] opnd;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUT 0 (illegal = NOP) with a small datapath around it
  logic       reset = 1'b0, run = 1'b0, reload_r = 1'b1;
  logic [7:0] mem_data, operand;
  logic       zero_flag, pc_load, pc_increment, addr_sel, mem_write_enable;
  logic       acc_load, halted, illegal;
  logic [3:0] alu_op;
  logic [2:0] state;

  cpu_control_unit #(.HALT_ON_ILLEGAL(1'b0), .ALU_PASS_B(4'h5)) dut0 (
    .clk(clk), .reset(reset), .run(run), .mem_data(mem_data), .zero_flag(zero_flag),
    .pc_load(pc_load), .pc_increment(pc_increment), .addr_sel(addr_sel),
    .operand(operand), .mem_write_enable(mem_write_enable), .acc_load(acc_load),
    .alu_op(alu_op), .halted(halted), .illegal(illegal), .state(state));

  logic [7:0] img [256];
  logic [7:0] e_mem [256];
  logic [7:0] e_pc, e_acc;

  function automatic logic [7:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return a & b;
      4'h3: return a | b;
      4'h4: return a ^ b;
      4'h5: return b;
      default: return 8'h00;
    endcase
  endfunction

  assign mem_data  = addr_sel ? e_mem[operand] : e_mem[e_pc];
  assign zero_flag = (alu(alu_op, e_acc, mem_data) == 8'h00);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_pc  <= 8'h00;
      e_acc <= 8'h00;
      if (reload_r) for (int i = 0; i < 256; i++) e_mem[i] <= img[i];
    end else begin
      if (pc_load) e_pc <= operand;
      else if (pc_increment) e_pc <= e_pc + 8'h01;
      if (acc_load) e_acc <= alu(alu_op, e_acc, mem_data);
      if (mem_write_enable) e_mem[operand] <= e_acc;
    end
  end

  function automatic vec_t obs0();
    vec_t v;
    v.st = state; v.hlt = halted; v.ill = illegal; v.pcl = pc_load;
    v.pci = pc_increment; v.asel = addr_sel; v.we = mem_write_enable;
    v.accl = acc_load; v.op = alu_op; v.opnd = operand;
    return v;
  endfunction

  // ---------------- DUT 1 (illegal = HALT), driven directly
  logic       reset1 = 1'b0, run1 = 1'b0;
  logic [7:0] md1 = 8'h00, operand1;
  logic       pcl1, pci1, asel1, we1, accl1, hlt1, ill1;
  logic [3:0] op1;
  logic [2:0] st1;

  cpu_control_unit #(.HALT_ON_ILLEGAL(1'b1), .ALU_PASS_B(4'h5)) dut1 (
    .clk(clk), .reset(reset1), .run(run1), .mem_data(md1), .zero_flag(1'b0),
    .pc_load(pcl1), .pc_increment(pci1), .addr_sel(asel1), .operand(operand1),
    .mem_write_enable(we1), .acc_load(accl1), .alu_op(op1), .halted(hlt1),
    .illegal(ill1), .state(st1));

  function automatic vec_t obs1();
    vec_t v;
    v.st = st1; v.hlt = hlt1; v.ill = ill1; v.pcl = pcl1; v.pci = pci1;
    v.asel = asel1; v.we = we1; v.accl = accl1; v.op = op1; v.opnd = operand1;
    return v;
  endfunction

  // ---------------- instruction-level reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_pc, m_acc, m_op;
  logic       m_z, m_halt;
  vec_t       q[$];

  task automatic exec_one();
    vec_t       v;
    logic [3:0] opc;
    logic [7:0] arg;
    chk("pc_at_fetch", e_pc, m_pc);
    chk("acc_at_fetch", e_acc, m_acc);
    opc = m_mem[m_pc][7:4];
    m_pc = m_pc + 8'h01;
    v = '0; v.pci = 1'b1; v.opnd = m_op; q.push_back(v);
    v = '0; v.st = 3'd1; v.opnd = m_op;
    if (opc == 4'h0) q.push_back(v);
    else if (opc == 4'hF) begin q.push_back(v); m_halt = 1'b1; end
    else if (opc >= 4'hB) begin v.ill = 1'b1; q.push_back(v); end
    else begin
      q.push_back(v);
      arg = m_mem[m_pc];
      m_pc = m_pc + 8'h01;
      v = '0; v.st = 3'd2; v.pci = 1'b1; v.opnd = m_op; q.push_back(v);
      m_op = arg;
      v = '0; v.st = 3'd3; v.asel = 1'b1; v.opnd = arg;
      case (opc)
        4'h1: begin m_acc = m_mem[arg];         v.op = 4'h5; v.accl = 1'b1; end
        4'h2: begin m_mem[arg] = m_acc;         v.we = 1'b1; end
        4'h3: begin m_acc = m_acc + m_mem[arg]; v.op = 4'h0; v.accl = 1'b1; end
        4'h4: begin m_acc = m_acc - m_mem[arg]; v.op = 4'h1; v.accl = 1'b1; end
        4'h5: begin m_acc = m_acc & m_mem[arg]; v.op = 4'h2; v.accl = 1'b1; end
        4'h6: begin m_acc = m_acc | m_mem[arg]; v.op = 4'h3; v.accl = 1'b1; end
        4'h7: begin m_acc = m_acc ^ m_mem[arg]; v.op = 4'h4; v.accl = 1'b1; end
        4'h8: begin v.pcl = 1'b1; m_pc = arg; end
        4'h9: if (m_z)  begin v.pcl = 1'b1; m_pc = arg; end
        default: if (!m_z) begin v.pcl = 1'b1; m_pc = arg; end
      endcase
      if (v.accl) m_z = (m_acc == 8'h00);
      q.push_back(v);
    end
  endtask

  task automatic step();
    vec_t v;
    if (q.size() == 0) begin
      v = '0; v.opnd = m_op;
      if (m_halt) begin v.st = 3'd4; v.hlt = 1'b1; q.push_back(v); end
      else if (!run) q.push_back(v);
      else exec_one();
    end
    v = q.pop_front();
    chk("cycle", obs0(), v);
  endtask

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom % 4) != 0;
  endfunction

  task automatic do_reset(input int mode, input logic reload);
    reload_r = reload;
    reset = 1'b0; run = 1'b1;
    #1 chk("reset_outputs", obs0(), 32'h0);
    @(posedge clk); @(negedge clk);
    run = pick(mode); reset = 1'b1;
    #1;
    q.delete();
    m_pc = 8'h00; m_acc = 8'h00; m_op = 8'h00; m_z = 1'b0; m_halt = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = img[i];
  endtask

  task automatic run_cycles(input int n, input int mode);
    for (int i = 0; i < n; i++) begin
      step();
      @(posedge clk); #1 run = pick(mode);
      @(negedge clk); #1;
    end
  endtask

  task automatic clear_img();
    for (int i = 0; i < 256; i++) img[i] = 8'h00;
  endtask

  initial begin
    vec_t v;
    // LDA 80 with mem[80]=0: pass-b load, zero flag set
    clear_img(); img[0] = 8'h10; img[1] = 8'h80;
    do_reset(1, 1'b1); run_cycles(6, 1);
    // LDA/ADD/HLT, then halted holds
    clear_img();
    img[0] = 8'h1F; img[1] = 8'h80; img[2] = 8'h30; img[3] = 8'h81; img[4] = 8'hFF;
    img[8'h80] = 8'h05; img[8'h81] = 8'h03;
    do_reset(1, 1'b1); run_cycles(34, 1);
    // JZ with z clear: falls through
    clear_img(); img[0] = 8'h90; img[1] = 8'h40;
    do_reset(1, 1'b1); run_cycles(8, 1);
    // LDA 0 sets z, then JZ 40 is taken; JNZ at 40 falls through
    clear_img(); img[0] = 8'h10; img[1] = 8'h80; img[2] = 8'h90; img[3] = 8'h40;
    img[8'h40] = 8'hA0; img[8'h41] = 8'h10;
    do_reset(1, 1'b1); run_cycles(16, 1);
    // illegal opcode treated as NOP
    clear_img(); img[0] = 8'hC0; img[1] = 8'hE5;
    do_reset(1, 1'b1); run_cycles(8, 1);
    // LDA 91 then STA 90: memory gets 33
    clear_img(); img[0] = 8'h10; img[1] = 8'h91; img[2] = 8'h20; img[3] = 8'h90;
    img[8'h91] = 8'h33; img[8'h90] = 8'h5A;
    do_reset(1, 1'b1); run_cycles(10, 1);
    chk("sta_mem", e_mem[8'h90], 8'h33);
    // reset during STA EXECUTE aborts the write; outputs clear at once
    clear_img(); img[0] = 8'h20; img[1] = 8'h90; img[8'h90] = 8'h5A;
    do_reset(1, 1'b1); run_cycles(3, 1);
    chk("sta_we_before_abort", mem_write_enable, 1'b1);
    reset = 1'b0;
    #1 chk("abort_outputs", obs0(), 32'h0);
    @(posedge clk); #1 chk("abort_no_write", e_mem[8'h90], 8'h5A);
    do_reset(0, 1'b0); run_cycles(10, 0);
    // random programs with random run
    for (int p = 0; p < 12; p++) begin
      for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
      img[0] = {4'($urandom_range(1, 10)), 4'h0};
      do_reset(2, 1'b1); run_cycles(150, 2);
    end
    // HALT_ON_ILLEGAL=1 instance
    reset1 = 1'b0; run1 = 1'b1; md1 = 8'hC0;
    @(posedge clk); @(negedge clk); reset1 = 1'b1;
    #1 v = '0; v.pci = 1'b1; chk("ill_fetch", obs1(), v);
    @(negedge clk); #1 v = '0; v.st = 3'd1; v.ill = 1'b1; chk("ill_decode", obs1(), v);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1 v = '0; v.st = 3'd4; v.hlt = 1'b1; chk("ill_halt", obs1(), v);
      run1 = 1'($urandom); md1 = 8'($urandom);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
